fpu_dot_sequencer: RTL and testbench
====================================

Name: fpu_dot_sequencer

Overview:
- Sequences a single-precision MAC datapath (multiplier feeding an accumulating adder) through an N-element dot product.
- Operand vectors A and B are preloaded into two internal register buffers. On start, the block clears the accumulator and issues element pairs with the stb/ack handshake the MAC expects.
- It collects the running sum and presents the final result with a one-cycle done pulse.
- It sits between the bus-facing register slave and the MAC core, so software no longer drives the MAC one element at a time.

Parameters:
- DEPTH, 8, number of entries in each operand buffer (power of two).
- ADDR_W, 3, log2(DEPTH); width of buffer index.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  buffer write strobe
- wr_sel  input  1  0 = write buffer A, 1 = write buffer B
- wr_addr  input  ADDR_W  buffer entry index
- wr_data  input  32  IEEE-754 single operand
- start  input  1  begin dot product (sampled in IDLE only)
- length  input  ADDR_W+1  element count, 0..DEPTH valid
- abort  input  1  cancel running operation
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, result valid
- err  output  1  one-cycle pulse, start rejected (length > DEPTH)
- result  output  32  last accumulated sum, held until next start
- mac_clear  output  1  one-cycle accumulator clear to MAC
- mac_a, mac_b  output  32 each  operand pair to multiplier
- mac_a_stb, mac_b_stb  output  1 each  operand valid strobes
- mac_a_ack, mac_b_ack  input  1 each  operand accepted
- mac_z  input  32  running sum from adder
- mac_z_stb  input  1  sum valid
- mac_z_ack  output  1  sum accepted

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, idx = 0.
  - busy, done, err, mac_clear, all stb, mac_z_ack = 0.
  - result, mac_a, mac_b = 0.
  - Buffer contents are undefined after reset.
- All outputs are registered.
- Buffers:
  - A write lands on the edge where wr_en is high; buffer[wr_sel][wr_addr] <= wr_data.
  - Writes are ignored while busy = 1.
  - A write and start in the same IDLE cycle: the write lands, and the new data is used.
- State IDLE:
  - start with length == 0: result <= 0x00000000, done pulses the next cycle, state stays IDLE, MAC untouched.
  - start with length > DEPTH: err pulses the next cycle, state stays IDLE, result unchanged.
  - start with length 1..DEPTH: latch length, go to CLEAR.
- State CLEAR: mac_clear = 1 for exactly this cycle; idx <= 0; go to ISSUE.
- State ISSUE:
  - Drive mac_a = A[idx], mac_b = B[idx].
  - Set mac_a_stb = mac_b_stb = 1.
  - Go to WAIT_ACK.
- State WAIT_ACK:
  - Each stb drops independently on the edge after its ack is seen high.
  - When both strobes have been acked (either order, or simultaneously), go to WAIT_Z.
  - mac_a and mac_b stay stable while their stb is high.
- State WAIT_Z:
  - mac_z_ack = 1.
  - On mac_z_stb = 1: result <= mac_z and mac_z_ack drops.
  - If idx == length-1, go to DONE; else idx <= idx+1 and go to ISSUE.
  - The next pair is never issued before the previous sum is accepted (accumulator feedback dependency).
- State DONE: done = 1 for one cycle; go to IDLE.
- Latency:
  - With a zero-wait MAC (ack in the same cycle as stb, z_stb one cycle later), each element costs 3 cycles.
  - Total from start accepted to done is 3*length + 2 cycles.
  - done is never held longer than 1 cycle.
- start while busy is ignored (no err).
- abort in any non-IDLE state:
  - All stb and mac_z_ack drop the next cycle.
  - mac_clear pulses once.
  - Go to IDLE; no done; result keeps its prior value.
  - abort in IDLE is ignored.
- abort and mac_z_stb in the same cycle: abort wins, and the sum is not captured.
- Reset asserted mid-operation: immediate return to reset values; the MAC must be reset by the same signal.

Test Plan:
- Dot product, length=3:
  - Stimulus: A = {0x3F800000, 0x40000000, 0x40400000} (1,2,3), B = {0x40800000, 0x40A00000, 0x40C00000} (4,5,6), behavioural MAC model.
  - Response: mac_clear pulses once, 3 issue/ack/sum rounds, result = 0x42000000 (32.0), one done pulse, busy low afterwards.
- length=0:
  - Stimulus: start with length = 0.
  - Response: done pulses the next cycle, result = 0, no mac_clear or stb activity, busy never high.
- length=DEPTH+1 (9):
  - Stimulus: start with length = 9.
  - Response: err pulses once, busy stays 0, result unchanged from the previous run.
- Skewed acks:
  - Stimulus: MAC acks a 2 cycles before b, then a 3-cycle z latency.
  - Response: mac_a_stb drops first; mac_b held stable until its ack; no issue until z is captured; correct 32.0 result.
- Abort on element 2 of 3:
  - Stimulus: assert abort while in WAIT_Z with mac_z_stb also high.
  - Response: sum not captured, mac_clear pulse, IDLE next cycle, no done.
  - Follow-up: a subsequent full run completes correctly.
- Write while busy plus reset mid-run:
  - Stimulus: write B[0] = 0x00000000 during a run; then assert reset low in ISSUE.
  - Response: the write is ignored (run result still 32.0); on reset, all outputs return to 0 asynchronously before the next clock.

Source files
------------

// File: rtl/fpu_dot_sequencer.sv
// fpu_dot_sequencer: walks preloaded A/B buffers through a stb/ack MAC datapath to form a dot product
module fpu_dot_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       result_o,
  output logic              mac_clear_o,
  output logic [31:0]       mac_a_o,
  output logic [31:0]       mac_b_o,
  output logic              mac_a_stb_o,
  output logic              mac_b_stb_o,
  input  logic              mac_a_ack_i,
  input  logic              mac_b_ack_i,
  input  logic [31:0]       mac_z_i,
  input  logic              mac_z_stb_i,
  output logic              mac_z_ack_o
);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT_ACK, WAIT_Z, DONE} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;
  logic              busy_q, done_q, err_q, clear_q, a_stb_q, b_stb_q, z_ack_q;
  logic [31:0]       result_q, mac_a_q, mac_b_q;
  logic [31:0]       buf_a_q [DEPTH];
  logic [31:0]       buf_b_q [DEPTH];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign result_o    = result_q;
  assign mac_clear_o = clear_q;
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign mac_a_stb_o = a_stb_q;
  assign mac_b_stb_o = b_stb_q;
  assign mac_z_ack_o = z_ack_q;
  // operand buffers: writable only while idle so a running product sees frozen data
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_q) begin
      if (wr_sel_i) buf_b_q[wr_addr_i] <= wr_data_i;
      else buf_a_q[wr_addr_i] <= wr_data_i;
    end
  end
  // sequencer: clear accumulator, then one issue/ack/sum round per element; abort returns to idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clear_q  <= 1'b0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      z_ack_q  <= 1'b0;
      result_q <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clear_q <= 1'b0;
      if (abort_i && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        clear_q <= 1'b1;
        a_stb_q <= 1'b0;
        b_stb_q <= 1'b0;
        z_ack_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            if (length_i == '0) begin
              result_q <= '0;
              done_q   <= 1'b1;
            end else if (length_i > MAX_LEN) begin
              err_q <= 1'b1;
            end else begin
              len_q   <= length_i;
              state_q <= CLEAR;
              busy_q  <= 1'b1;
              clear_q <= 1'b1;
            end
          end
          CLEAR: begin
            idx_q   <= '0;
            state_q <= ISSUE;
          end
          ISSUE: begin
            mac_a_q <= buf_a_q[idx_q];
            mac_b_q <= buf_b_q[idx_q];
            a_stb_q <= 1'b1;
            b_stb_q <= 1'b1;
            state_q <= WAIT_ACK;
          end
          WAIT_ACK: begin
            a_stb_q <= a_stb_q & ~mac_a_ack_i;
            b_stb_q <= b_stb_q & ~mac_b_ack_i;
            if ((!a_stb_q || mac_a_ack_i) && (!b_stb_q || mac_b_ack_i)) begin
              state_q <= WAIT_Z;
              z_ack_q <= 1'b1;
            end
          end
          WAIT_Z: if (mac_z_stb_i) begin
            result_q <= mac_z_i;
            z_ack_q  <= 1'b0;
            if ({1'b0, idx_q} == len_q - 1'b1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ISSUE;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// tb_fpu_dot_sequencer: random and directed dot products against an integer-valued float MAC model
module tb_fpu_dot_sequencer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic wr_en_i = 0, wr_sel_i = 0, start_i = 0, abort_i = 0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [AW:0] length_i = '0;
  logic busy_o, done_o, err_o, mac_clear_o, mac_a_stb_o, mac_b_stb_o, mac_z_ack_o;
  logic [31:0] result_o, mac_a_o, mac_b_o;
  logic mac_a_ack_i = 0, mac_b_ack_i = 0, mac_z_stb_i = 0;
  logic [31:0] mac_z_i = '0;
  int errors = 0, checks = 0;
  int ref_a [DEPTH];
  int ref_b [DEPTH];
  int ack_a_dly = 0, ack_b_dly = 0, z_dly = 1;
  int n_clear = 0, n_done = 0, n_err = 0, n_stb = 0, n_busy = 0, n_skew = 0, rounds = 0;
  int acc = 0, a_wait = 0, b_wait = 0, zcnt = 0;
  logic got_a = 0, got_b = 0, pend = 0, zcons = 0, prev_astb = 0;
  logic [31:0] op_a = '0, op_b = '0;
  always #5 clk_i = ~clk_i;
  fpu_dot_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .start_i(start_i), .length_i(length_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .mac_clear_o(mac_clear_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o),
    .mac_a_stb_o(mac_a_stb_o), .mac_b_stb_o(mac_b_stb_o), .mac_a_ack_i(mac_a_ack_i),
    .mac_b_ack_i(mac_b_ack_i), .mac_z_i(mac_z_i), .mac_z_stb_i(mac_z_stb_i),
    .mac_z_ack_o(mac_z_ack_o)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] i2f(int v);
    int m, p;
    if (v == 0) return 32'h0;
    m = v < 0 ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if ((m >> i) != 0) p = i;
    return {v < 0, 8'(127 + p), 23'(m << (23 - p))};
  endfunction
  function automatic int f2i(logic [31:0] f);
    int e, v;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    v = int'({1'b1, f[22:0]}) >>> (23 - e);
    return f[31] ? -v : v;
  endfunction
  // monitor plus behavioural MAC: acks after a programmable wait, sum after a programmable latency
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mac_a_ack_i = 0; mac_b_ack_i = 0; mac_z_stb_i = 0;
      got_a = 0; got_b = 0; pend = 0; acc = 0; rounds = 0; a_wait = 0; b_wait = 0; prev_astb = 0;
    end else begin
      n_clear += int'(mac_clear_o); n_done += int'(done_o); n_err += int'(err_o); n_busy += int'(busy_o);
      if (mac_a_stb_o && !prev_astb) n_stb++;
      if (!mac_a_stb_o && mac_b_stb_o) n_skew++;
      prev_astb = mac_a_stb_o;
      if (mac_a_stb_o && rounds < DEPTH) check("mac_a_operand", mac_a_o, i2f(ref_a[rounds]));
      if (mac_b_stb_o && rounds < DEPTH) check("mac_b_operand", mac_b_o, i2f(ref_b[rounds]));
      if (pend) check("issue_before_sum", {30'h0, mac_a_stb_o, mac_b_stb_o}, 32'h0);
      mac_a_ack_i = 0; mac_b_ack_i = 0;
      if (mac_clear_o) begin
        acc = 0; got_a = 0; got_b = 0; pend = 0; mac_z_stb_i = 0; a_wait = 0; b_wait = 0; rounds = 0;
      end else begin
        if (mac_z_stb_i && zcons) begin
          acc = acc + f2i(op_a) * f2i(op_b);
          mac_z_stb_i = 0; pend = 0; rounds++;
        end
        if (mac_a_stb_o && !got_a) begin
          if (a_wait >= ack_a_dly) begin mac_a_ack_i = 1; got_a = 1; op_a = mac_a_o; end
          else a_wait++;
        end
        if (mac_b_stb_o && !got_b) begin
          if (b_wait >= ack_b_dly) begin mac_b_ack_i = 1; got_b = 1; op_b = mac_b_o; end
          else b_wait++;
        end
        if (got_a && got_b && !pend) begin
          pend = 1; zcnt = 0; got_a = 0; got_b = 0; a_wait = 0; b_wait = 0;
        end else if (pend && !mac_z_stb_i) begin
          zcnt++;
          if (zcnt >= z_dly) begin
            mac_z_stb_i = 1;
            mac_z_i = i2f(acc + f2i(op_a) * f2i(op_b));
            zcons = mac_z_ack_o;
          end
        end else if (mac_z_stb_i) zcons = mac_z_ack_o;
      end
    end
  end
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask
  task automatic wr(bit sel, int addr, int v);
    wr_en_i = 1; wr_sel_i = sel; wr_addr_i = AW'(addr); wr_data_i = i2f(v);
    if (sel) ref_b[addr] = v; else ref_a[addr] = v;
    tick();
    wr_en_i = 0;
  endtask
  task automatic run(int len, bit poke, int ws, output int lat);
    int exp_sum, b_clear, b_done, b_stb;
    if (ws >= 0) begin
      wr_en_i = 1; wr_sel_i = 0; wr_addr_i = '0; wr_data_i = i2f(ws); ref_a[0] = ws;
    end
    exp_sum = 0;
    for (int i = 0; i < len; i++) exp_sum += ref_a[i] * ref_b[i];
    b_clear = n_clear; b_done = n_done; b_stb = n_stb;
    start_i = 1; length_i = 4'(len);
    tick();
    start_i = 0; wr_en_i = 0; lat = 1;
    while (!done_o && lat < 1000) begin
      if (poke && lat == 2) begin
        wr_en_i = 1; wr_sel_i = 1; wr_addr_i = '0; wr_data_i = 32'h0;
      end else wr_en_i = 0;
      tick();
      lat++;
    end
    wr_en_i = 0;
    check("done_seen", {31'h0, done_o}, 32'h1);
    check("result", result_o, i2f(exp_sum));
    tick();
    check("busy_after_done", {31'h0, busy_o}, 32'h0);
    check("done_pulses", n_done - b_done, 1);
    check("clear_pulses", n_clear - b_clear, 1);
    check("issue_rounds", n_stb - b_stb, len);
  endtask
  initial begin
    int lat, b_err, b_busy, b_clear, b_done, b_stb, guard;
    repeat (3) tick();
    check("reset_ctrl", {25'h0, busy_o, done_o, err_o, mac_clear_o, mac_a_stb_o, mac_b_stb_o, mac_z_ack_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    check("reset_mac_a", mac_a_o, 32'h0);
    check("reset_mac_b", mac_b_o, 32'h0);
    rst_ni = 1;
    tick();
    for (int i = 0; i < 3; i++) begin wr(0, i, i + 1); wr(1, i, i + 4); end
    run(3, 0, -1, lat);
    check("dot3_value", result_o, 32'h42000000);
    check("dot3_latency", lat, 11);
    b_err = n_err; b_busy = n_busy;
    start_i = 1; length_i = 4'd9;
    tick();
    start_i = 0;
    check("len9_err", {31'h0, err_o}, 32'h1);
    tick();
    check("len9_err_pulses", n_err - b_err, 1);
    check("len9_busy", n_busy - b_busy, 0);
    check("len9_result_kept", result_o, 32'h42000000);
    b_done = n_done; b_clear = n_clear; b_stb = n_stb; b_busy = n_busy;
    start_i = 1; length_i = 4'd0;
    tick();
    start_i = 0;
    check("len0_done", {31'h0, done_o}, 32'h1);
    check("len0_result", result_o, 32'h0);
    tick();
    check("len0_done_pulses", n_done - b_done, 1);
    check("len0_no_clear", n_clear - b_clear, 0);
    check("len0_no_stb", n_stb - b_stb, 0);
    check("len0_busy", n_busy - b_busy, 0);
    abort_i = 1;
    tick();
    abort_i = 0;
    check("idle_abort", {30'h0, busy_o, mac_clear_o}, 32'h0);
    ack_b_dly = 2; z_dly = 3;
    b_stb = n_skew;
    run(3, 0, -1, lat);
    check("skew_value", result_o, 32'h42000000);
    check("skew_b_held", n_skew - b_stb, 6);
    ack_b_dly = 0; z_dly = 1;
    b_done = n_done; b_clear = n_clear;
    start_i = 1; length_i = 4'd3;
    tick();
    start_i = 0; guard = 0;
    while (!(mac_z_stb_i && rounds == 1) && guard < 100) begin tick(); guard++; end
    check("abort_reached", {31'h0, mac_z_stb_i}, 32'h1);
    abort_i = 1;
    tick();
    abort_i = 0;
    check("abort_idle", {28'h0, busy_o, mac_a_stb_o, mac_b_stb_o, mac_z_ack_o}, 32'h0);
    check("abort_clear", {31'h0, mac_clear_o}, 32'h1);
    check("abort_result", result_o, 32'h40800000);
    repeat (4) tick();
    check("abort_no_done", n_done - b_done, 0);
    check("abort_clears", n_clear - b_clear, 2);
    run(3, 0, -1, lat);
    run(3, 1, -1, lat);
    check("busy_write_ignored", result_o, 32'h42000000);
    start_i = 1; length_i = 4'd3;
    tick();
    start_i = 0;
    check("rst_test_clear", {31'h0, mac_clear_o}, 32'h1);
    tick();
    rst_ni = 0;
    #1;
    check("async_rst_ctrl", {25'h0, busy_o, done_o, err_o, mac_clear_o, mac_a_stb_o, mac_b_stb_o, mac_z_ack_o}, 32'h0);
    check("async_rst_result", result_o, 32'h0);
    check("async_rst_mac", mac_a_o | mac_b_o, 32'h0);
    tick();
    rst_ni = 1;
    tick();
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wr(0, i, int'($urandom_range(30)) - 15);
        wr(1, i, int'($urandom_range(30)) - 15);
      end
      ack_a_dly = (r % 3 == 0) ? 0 : int'($urandom_range(3));
      ack_b_dly = (r % 3 == 0) ? 0 : int'($urandom_range(3));
      z_dly = (r % 3 == 0) ? 1 : int'($urandom_range(1, 3));
      run(int'($urandom_range(1, DEPTH)), 1'($urandom_range(1)), (r % 4 == 1) ? int'($urandom_range(9)) : -1, lat);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
